// File: rtl/ubx_pkg.sv
// Shared UBX protocol constants, NAV field offsets and receiver state encoding.
package ubx_pkg;

  localparam logic [7:0]  UBX_SYNC_1 = 8'hB5;
  localparam logic [7:0]  UBX_SYNC_2 = 8'h62;
  localparam logic [7:0]  CLS_NAV    = 8'h01;
  localparam logic [7:0]  ID_POSLLH  = 8'h02;
  localparam logic [7:0]  ID_VELNED  = 8'h12;

  localparam logic [15:0] LEN_POSLLH = 16'd28;
  localparam logic [15:0] LEN_VELNED = 16'd36;

  localparam logic [15:0] OFF_ITOW   = 16'd0;
  localparam logic [15:0] OFF_LON    = 16'd4;
  localparam logic [15:0] OFF_LAT    = 16'd8;
  localparam logic [15:0] OFF_HEIGHT = 16'd12;
  localparam logic [15:0] OFF_GSPEED = 16'd20;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC2,
    ST_CLASS,
    ST_ID,
    ST_LEN_L,
    ST_LEN_H,
    ST_PAYLOAD,
    ST_CK_A,
    ST_CK_B
  } state_t;

  typedef struct packed {
    logic [31:0] itow;
    logic [31:0] lon;
    logic [31:0] lat;
    logic [31:0] height;
  } pos_t;

  // All NAV fields are 4-byte aligned, so a word compare selects the field.
  function automatic logic in_field(input logic [15:0] idx, input logic [15:0] off);
    return idx[15:2] == off[15:2];
  endfunction

endpackage

// File: rtl/ubx_fletcher8.sv
// Fletcher-8 running checksum; ck_a/ck_b include every byte enabled before the current edge.
// No backpressure: one byte per en strobe, clr has priority over en.
module ubx_fletcher8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] din,
  output logic [7:0] ck_a,
  output logic [7:0] ck_b
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ck_a <= '0;
      ck_b <= '0;
    end else if (clr) begin
      ck_a <= '0;
      ck_b <= '0;
    end else if (en) begin
      ck_a <= ck_a + din;
      ck_b <= ck_b + ck_a + din;
    end
  end

endmodule

// File: rtl/ubx_nav_receiver.sv
// UBX NAV-POSLLH / NAV-VELNED stream decoder; outputs and valid pulses update one cycle after CK_B.
// No backpressure: every rx_new byte is consumed; bad or oversize frames only bump the error counters.
module ubx_nav_receiver
  import ubx_pkg::*;
#(
  parameter int MAX_PAYLOAD    = 256,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       rx_data,
  input  logic             rx_new,
  output logic [31:0]      itow,
  output logic [31:0]      lon,
  output logic [31:0]      lat,
  output logic [31:0]      height,
  output logic [31:0]      ground_speed,
  output logic             pos_valid,
  output logic             vel_valid,
  output logic             in_frame,
  output logic [CNT_W-1:0] cks_err_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [16:0] MAX_LEN = 17'(MAX_PAYLOAD);

  state_t        state;
  logic [7:0]    cls;
  logic [7:0]    id;
  logic [15:0]   len;
  logic [15:0]   idx;
  logic [TW-1:0] timer;
  logic          cka_ok;
  pos_t          pos_sh;
  pos_t          pos_q;
  logic [31:0]   gspeed_sh;

  logic [7:0]    ck_a;
  logic [7:0]    ck_b;
  logic          ck_clr;
  logic          ck_en;
  logic [15:0]   len_full;
  logic          is_pos;
  logic          is_vel;
  logic          is_known;
  logic [4:0]    bsel;

  assign ck_clr   = rx_new && (state == ST_SYNC2) && (rx_data == UBX_SYNC_2);
  assign ck_en    = rx_new && (state inside {ST_CLASS, ST_ID, ST_LEN_L, ST_LEN_H, ST_PAYLOAD});
  assign len_full = {rx_data, len[7:0]};
  assign is_known = (cls == CLS_NAV) && ((id == ID_POSLLH) || (id == ID_VELNED));
  assign is_pos   = (cls == CLS_NAV) && (id == ID_POSLLH) && (len == LEN_POSLLH);
  assign is_vel   = (cls == CLS_NAV) && (id == ID_VELNED) && (len == LEN_VELNED);
  assign bsel     = {idx[1:0], 3'b000};

  assign in_frame     = (state != ST_IDLE);
  assign itow         = pos_q.itow;
  assign lon          = pos_q.lon;
  assign lat          = pos_q.lat;
  assign height       = pos_q.height;

  ubx_fletcher8 u_cks (
    .clk  (clk),
    .rst  (rst),
    .clr  (ck_clr),
    .en   (ck_en),
    .din  (rx_data),
    .ck_a (ck_a),
    .ck_b (ck_b)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      cls          <= '0;
      id           <= '0;
      len          <= '0;
      idx          <= '0;
      timer        <= '0;
      cka_ok       <= 1'b0;
      pos_sh       <= '0;
      pos_q        <= '0;
      gspeed_sh    <= '0;
      ground_speed <= '0;
      pos_valid    <= 1'b0;
      vel_valid    <= 1'b0;
      cks_err_cnt  <= '0;
      drop_cnt     <= '0;
    end else begin
      pos_valid <= 1'b0;
      vel_valid <= 1'b0;
      if (rx_new) begin
        timer <= '0;
        case (state)
          ST_IDLE: if (rx_data == UBX_SYNC_1) state <= ST_SYNC2;
          ST_SYNC2: begin
            if (rx_data == UBX_SYNC_2)      state <= ST_CLASS;
            else if (rx_data != UBX_SYNC_1) state <= ST_IDLE;
          end
          ST_CLASS: begin
            cls   <= rx_data;
            state <= ST_ID;
          end
          ST_ID: begin
            id    <= rx_data;
            state <= ST_LEN_L;
          end
          ST_LEN_L: begin
            len[7:0] <= rx_data;
            state    <= ST_LEN_H;
          end
          ST_LEN_H: begin
            len[15:8] <= rx_data;
            idx       <= '0;
            if ({1'b0, len_full} > MAX_LEN) begin
              state    <= ST_IDLE;
              drop_cnt <= sat_inc(drop_cnt);
            end else if (len_full == 16'd0) begin
              state <= ST_CK_A;
            end else begin
              state <= ST_PAYLOAD;
            end
          end
          ST_PAYLOAD: begin
            // Shadows may be overwritten by a frame that later fails; outputs copy only on success.
            if (is_pos) begin
              if (in_field(idx, OFF_ITOW))   pos_sh.itow[bsel +: 8]   <= rx_data;
              if (in_field(idx, OFF_LON))    pos_sh.lon[bsel +: 8]    <= rx_data;
              if (in_field(idx, OFF_LAT))    pos_sh.lat[bsel +: 8]    <= rx_data;
              if (in_field(idx, OFF_HEIGHT)) pos_sh.height[bsel +: 8] <= rx_data;
            end
            if (is_vel && in_field(idx, OFF_GSPEED)) gspeed_sh[bsel +: 8] <= rx_data;
            if (idx == len - 16'd1) state <= ST_CK_A;
            else                    idx   <= idx + 16'd1;
          end
          ST_CK_A: begin
            cka_ok <= (rx_data == ck_a);
            state  <= ST_CK_B;
          end
          ST_CK_B: begin
            state <= ST_IDLE;
            if (!cka_ok || (rx_data != ck_b)) begin
              cks_err_cnt <= sat_inc(cks_err_cnt);
            end else if (is_pos) begin
              pos_q     <= pos_sh;
              pos_valid <= 1'b1;
            end else if (is_vel) begin
              ground_speed <= gspeed_sh;
              vel_valid    <= 1'b1;
            end else if (is_known) begin
              drop_cnt <= sat_inc(drop_cnt);
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
          state    <= ST_IDLE;
          timer    <= '0;
          drop_cnt <= sat_inc(drop_cnt);
        end else begin
          timer <= timer + TW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ubx_nav_receiver.sv
// Bench for ubx_nav_receiver: directed frame table, timeout/reset sequences, random frames vs frame-level model.
`timescale 1ns/1ps
module tb_ubx_nav_receiver;

  localparam int MAX_P   = 256;
  localparam int TMO     = 64;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
  localparam logic [31:0] H0 = 32'hFFFF_EC78; // -5000

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_new;
  logic [31:0]   itow, lon, lat, height, ground_speed;
  logic          pos_valid, vel_valid, in_frame;
  logic [CW-1:0] cks_err_cnt, drop_cnt;

  ubx_nav_receiver #(.MAX_PAYLOAD(MAX_P), .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_new(rx_new),
    .itow(itow), .lon(lon), .lat(lat), .height(height), .ground_speed(ground_speed),
    .pos_valid(pos_valid), .vel_valid(vel_valid), .in_frame(in_frame),
    .cks_err_cnt(cks_err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [7:0]  cls, id;
    logic [15:0] len;
    logic [31:0] f_itow, f_lon, f_lat, f_height, f_gs;
    logic [7:0]  cka_x, ckb_x;
    bit          extra_b5, hdr_only;
    bit          e_pos, e_vel;
    logic [31:0] e_itow, e_lon, e_lat, e_height, e_gs;
    int          e_cks, e_drop;
  } vec_t;

  vec_t tbl [12];

  int n_checks = 0;
  int n_fail   = 0;
  int pos_pulses = 0, vel_pulses = 0, wide_pulses = 0;
  logic prev_pv = 1'b0, prev_vv = 1'b0;

  logic [31:0] m_itow, m_lon, m_lat, m_height, m_gs;
  int          m_cks, m_drop;

  always @(negedge clk) begin
    if (pos_valid === 1'b1) pos_pulses++;
    if (vel_valid === 1'b1) vel_pulses++;
    if ((pos_valid === 1'b1 && prev_pv) || (vel_valid === 1'b1 && prev_vv)) wide_pulses++;
    prev_pv = (pos_valid === 1'b1);
    prev_vv = (vel_valid === 1'b1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int x);
    return (x >= CNT_MAX) ? CNT_MAX : x + 1;
  endfunction

  function automatic logic [7:0] pay_byte(input vec_t v, input int i);
    logic [127:0] pos;
    pos = {v.f_height, v.f_lat, v.f_lon, v.f_itow};
    if (i < 16) return pos[8*i +: 8];
    if (i >= 20 && i < 24) return v.f_gs[8*(i-20) +: 8];
    return 8'($urandom);
  endfunction

  // Frame-level outcome from the protocol rules: at most one effect per frame.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    r = v;
    r.e_pos = 1'b0;
    r.e_vel = 1'b0;
    if (int'(v.len) > MAX_P) m_drop = sat(m_drop);
    else if (v.cka_x != 8'h00 || v.ckb_x != 8'h00) m_cks = sat(m_cks);
    else if (v.cls == 8'h01 && v.id == 8'h02) begin
      if (v.len == 16'd28) begin
        m_itow = v.f_itow; m_lon = v.f_lon; m_lat = v.f_lat; m_height = v.f_height;
        r.e_pos = 1'b1;
      end else m_drop = sat(m_drop);
    end else if (v.cls == 8'h01 && v.id == 8'h12) begin
      if (v.len == 16'd36) begin
        m_gs = v.f_gs;
        r.e_vel = 1'b1;
      end else m_drop = sat(m_drop);
    end
    r.e_itow = m_itow; r.e_lon = m_lon; r.e_lat = m_lat; r.e_height = m_height; r.e_gs = m_gs;
    r.e_cks = m_cks; r.e_drop = m_drop;
    return r;
  endfunction

  function automatic vec_t rand_vec(input int kind);
    vec_t v;
    v.name = $sformatf("rnd_k%0d", kind);
    v.cls = 8'h01; v.id = 8'h02; v.len = 16'd28;
    v.f_itow = $urandom; v.f_lon = $urandom; v.f_lat = $urandom; v.f_height = $urandom; v.f_gs = $urandom;
    v.cka_x = 8'h00; v.ckb_x = 8'h00; v.extra_b5 = 1'b0; v.hdr_only = 1'b0;
    case (kind)
      0: v.extra_b5 = 1'($urandom);
      1: begin v.id = 8'h12; v.len = 16'd36; v.extra_b5 = 1'($urandom); end
      2: v.cka_x = 8'($urandom_range(1, 255));
      3: begin v.id = 8'h12; v.len = 16'd36; v.ckb_x = 8'($urandom_range(1, 255)); end
      4: begin
        v.id  = ($urandom_range(0, 1) == 0) ? 8'h02 : 8'h12;
        v.len = 16'($urandom_range(0, 40));
        if (v.id == 8'h02 && v.len == 16'd28) v.len = 16'd27;
        if (v.id == 8'h12 && v.len == 16'd36) v.len = 16'd35;
      end
      5: begin v.cls = 8'($urandom_range(2, 255)); v.id = 8'($urandom); v.len = 16'($urandom_range(0, 40)); end
      default: begin v.len = 16'($urandom_range(MAX_P + 1, 65535)); v.hdr_only = 1'b1; end
    endcase
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_new  = 1'b1;
    @(negedge clk);
    rx_new  = 1'b0;
  endtask

  task automatic do_frame(input vec_t v, input int junk_n, input int max_gap);
    logic [7:0] q[$];
    logic [7:0] a, b, j;
    int p0, v0;
    logic pv_end, vv_end;
    p0 = pos_pulses;
    v0 = vel_pulses;
    for (int i = 0; i < junk_n; i++) begin
      j = 8'($urandom);
      if (j == 8'hB5) j = 8'h00;
      send_byte(j);
    end
    q = {v.cls, v.id, v.len[7:0], v.len[15:8]};
    if (!v.hdr_only) for (int i = 0; i < int'(v.len); i++) q.push_back(pay_byte(v, i));
    a = 8'h00;
    b = 8'h00;
    foreach (q[i]) begin
      a = a + q[i];
      b = b + a;
    end
    if (v.extra_b5) send_byte(8'hB5);
    send_byte(8'hB5);
    send_byte(8'h62);
    foreach (q[i]) begin
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(q[i]);
    end
    if (!v.hdr_only) begin
      send_byte(a ^ v.cka_x);
      repeat ($urandom_range(0, max_gap)) @(negedge clk);
      send_byte(b ^ v.ckb_x);
    end
    pv_end = pos_valid;
    vv_end = vel_valid;
    repeat (3) @(negedge clk);
    check({v.name, " pos_pulses"}, pos_pulses - p0, v.e_pos);
    check({v.name, " vel_pulses"}, vel_pulses - v0, v.e_vel);
    check({v.name, " pos_valid_after_ckb"}, pv_end, v.e_pos);
    check({v.name, " vel_valid_after_ckb"}, vv_end, v.e_vel);
    check({v.name, " itow"}, itow, v.e_itow);
    check({v.name, " lon"}, lon, v.e_lon);
    check({v.name, " lat"}, lat, v.e_lat);
    check({v.name, " height"}, height, v.e_height);
    check({v.name, " ground_speed"}, ground_speed, v.e_gs);
    check({v.name, " cks_err_cnt"}, cks_err_cnt, v.e_cks);
    check({v.name, " drop_cnt"}, drop_cnt, v.e_drop);
    check({v.name, " in_frame"}, in_frame, 1'b0);
  endtask

  initial begin
    vec_t v;
    int p0;

    tbl[0]  = '{"posllh_ok", 8'h01, 8'h02, 16'd28, 32'd1000, 32'h12345678, 32'h87654321, H0, 32'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1000, 32'h12345678, 32'h87654321, H0, 32'd0, 0, 0};
    tbl[1]  = '{"velned_ok", 8'h01, 8'h12, 16'd36, 32'd1, 32'd2, 32'd3, 32'd4, 32'h000001F4, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1000, 32'h12345678, 32'h87654321, H0, 32'd500, 0, 0};
    tbl[2]  = '{"posllh_bad_cka", 8'h01, 8'h02, 16'd28, 32'd2000, 32'd1, 32'd2, 32'd3, 32'd0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 32'h12345678, 32'h87654321, H0, 32'd500, 1, 0};
    tbl[3]  = '{"resync_velned", 8'h01, 8'h12, 16'd36, 32'd5, 32'd6, 32'd7, 32'd8, 32'h00001234, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1000, 32'h12345678, 32'h87654321, H0, 32'h00001234, 1, 0};
    tbl[4]  = '{"posllh_len20", 8'h01, 8'h02, 16'd20, 32'd3000, 32'd4, 32'd5, 32'd6, 32'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1000, 32'h12345678, 32'h87654321, H0, 32'h00001234, 1, 1};
    tbl[5]  = '{"posllh_after_drop", 8'h01, 8'h02, 16'd28, 32'd4000, 32'hCAFEBABE, 32'h0BADF00D, 32'd123456, 32'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'd4000, 32'hCAFEBABE, 32'h0BADF00D, 32'd123456, 32'h00001234, 1, 1};
    tbl[6]  = '{"unknown_ok", 8'h05, 8'h01, 16'd2, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4000, 32'hCAFEBABE, 32'h0BADF00D, 32'd123456, 32'h00001234, 1, 1};
    tbl[7]  = '{"unknown_bad_ckb", 8'h0A, 8'h04, 16'd7, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 8'h00, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4000, 32'hCAFEBABE, 32'h0BADF00D, 32'd123456, 32'h00001234, 2, 1};
    tbl[8]  = '{"velned_bad_ckb", 8'h01, 8'h12, 16'd36, 32'd9, 32'd9, 32'd9, 32'd9, 32'd999, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4000, 32'hCAFEBABE, 32'h0BADF00D, 32'd123456, 32'h00001234, 3, 1};
    tbl[9]  = '{"len_0x0200", 8'h01, 8'h02, 16'h0200, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'd4000, 32'hCAFEBABE, 32'h0BADF00D, 32'd123456, 32'h00001234, 3, 2};
    tbl[10] = '{"posllh_len0", 8'h01, 8'h02, 16'd0, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4000, 32'hCAFEBABE, 32'h0BADF00D, 32'd123456, 32'h00001234, 3, 3};
    tbl[11] = '{"unknown_len256", 8'h02, 8'h13, 16'd256, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 32'd4000, 32'hCAFEBABE, 32'h0BADF00D, 32'd123456, 32'h00001234, 3, 3};

    rst = 1'b1;
    rx_new = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("reset itow", itow, 32'd0);
    check("reset lon", lon, 32'd0);
    check("reset ground_speed", ground_speed, 32'd0);
    check("reset in_frame", in_frame, 1'b0);
    check("reset pos_valid", pos_valid, 1'b0);
    check("reset cks_err_cnt", cks_err_cnt, 0);
    check("reset drop_cnt", drop_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 12; i++) do_frame(tbl[i], 0, 2);

    m_itow = tbl[11].e_itow; m_lon = tbl[11].e_lon; m_lat = tbl[11].e_lat;
    m_height = tbl[11].e_height; m_gs = tbl[11].e_gs;
    m_cks = tbl[11].e_cks; m_drop = tbl[11].e_drop;

    // Stall mid-payload: frame must be abandoned after exactly TMO idle cycles.
    send_byte(8'hB5); send_byte(8'h62); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h1C); send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(8'($urandom));
    repeat (TMO - 1) @(negedge clk);
    check("timeout in_frame_before", in_frame, 1'b1);
    @(negedge clk);
    check("timeout in_frame_after", in_frame, 1'b0);
    m_drop = sat(m_drop);
    check("timeout drop_cnt", drop_cnt, m_drop);
    check("timeout itow_held", itow, m_itow);

    for (int n = 0; n < 50; n++) begin
      v = predict(rand_vec($urandom_range(0, 6)));
      do_frame(v, $urandom_range(0, 3), 3);
    end

    for (int n = 0; n < 18; n++) begin
      v = rand_vec(5);
      v.cka_x = 8'h5A;
      v.name = "sat_cks";
      do_frame(predict(v), 0, 1);
    end
    check("sat cks_err_cnt", cks_err_cnt, CNT_MAX);
    for (int n = 0; n < 18; n++) begin
      v = rand_vec(6);
      v.name = "sat_drop";
      do_frame(predict(v), 0, 1);
    end
    check("sat drop_cnt", drop_cnt, CNT_MAX);

    // Reset in the middle of a POSLLH payload.
    p0 = pos_pulses;
    send_byte(8'hB5); send_byte(8'h62); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h1C); send_byte(8'h00);
    for (int i = 0; i < 10; i++) send_byte(8'($urandom));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst in_frame", in_frame, 1'b0);
    check("midrst itow", itow, 32'd0);
    check("midrst height", height, 32'd0);
    check("midrst cks_err_cnt", cks_err_cnt, 0);
    check("midrst drop_cnt", drop_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst pos_pulses", pos_pulses - p0, 0);
    m_itow = '0; m_lon = '0; m_lat = '0; m_height = '0; m_gs = '0; m_cks = 0; m_drop = 0;
    v = rand_vec(0);
    v.name = "post_reset_posllh";
    do_frame(predict(v), 1, 2);

    check("valid pulses single-cycle", wide_pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ubx_nav_receiver.md
UBX_NAV_RECEIVER -- requirements
Module: ubx_nav_receiver

Interface
REQ-001 Parameter MAX_PAYLOAD, default 256: largest accepted UBX payload length in bytes; longer frames are dropped.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: idle clk cycles inside a frame before the frame is abandoned.
REQ-003 Parameter CNT_W, default 16: width of the error counters.
REQ-004 clk  input  1  clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 rx_data  input  8  received UART byte, valid when rx_new=1.
REQ-007 rx_new  input  1  one-cycle strobe per received byte.
REQ-008 itow  output  32  NAV-POSLLH iTOW, ms.
REQ-009 lon  output  32  NAV-POSLLH longitude, 1e-7 deg.
REQ-010 lat  output  32  NAV-POSLLH latitude, 1e-7 deg.
REQ-011 height  output  32  NAV-POSLLH height above ellipsoid, mm.
REQ-012 ground_speed  output  32  NAV-VELNED gSpeed, cm/s.
REQ-013 pos_valid  output  1  one-cycle pulse when itow/lon/lat/height update.
REQ-014 vel_valid  output  1  one-cycle pulse when ground_speed updates.
REQ-015 in_frame  output  1  high while in any state other than IDLE.
REQ-016 cks_err_cnt  output  CNT_W  count of frames failing checksum, saturating.
REQ-017 drop_cnt  output  CNT_W  count of frames dropped for length, oversize or timeout, saturating.

Function
REQ-018 States: IDLE, SYNC2, CLASS, ID, LEN_L, LEN_H, PAYLOAD, CK_A, CK_B; each state advances only on rx_new.
REQ-019 IDLE -> SYNC2 on byte 0xB5.
REQ-020 SYNC2 -> CLASS on 0x62; stays in SYNC2 on 0xB5 (resync); any other byte -> IDLE.
REQ-021 Length field is little-endian 16 bit; LEN_H -> PAYLOAD when length > 0, and -> CK_A when length = 0.
REQ-022 In LEN_H, length > MAX_PAYLOAD -> IDLE with drop_cnt+1.
REQ-023 PAYLOAD holds a 16-bit byte index from 0 and exits to CK_A after the byte at index length-1.
REQ-024 Fletcher-8 checksum: CK_A+=byte; CK_B+=CK_A, mod 256, over class, id, both length bytes and the payload; cleared on entry to CLASS.
REQ-025 Class/ID 0x01/0x02 with length 28 is POSLLH; payload offsets 0-3 iTOW, 4-7 lon, 8-11 lat, 12-15 height, little-endian, captured into shadow registers.
REQ-026 Class/ID 0x01/0x12 with length 36 is VELNED; offsets 20-23 gSpeed captured into shadow.
REQ-027 Known class/ID with the wrong length: consume the whole frame, capture nothing, drop_cnt+1 at CK_B; never lock up.
REQ-028 Unknown class/ID: consume the frame silently; counted only on checksum failure.
REQ-029 CK_B byte: if both checksum bytes match, copy shadow to outputs and pulse pos_valid or vel_valid in the cycle after the CK_B byte; on mismatch, outputs are unchanged and cks_err_cnt+1. Next state IDLE.
REQ-030 Timeout: in any state other than IDLE, TIMEOUT_CYCLES consecutive cycles without rx_new -> IDLE with drop_cnt+1; the timer resets on every rx_new.
REQ-031 Counters saturate at all ones; simultaneous increment sources cannot occur (one event per frame).
REQ-032 Outputs never show a partially updated frame.

Reset
REQ-033 rst clears all outputs, shadows, counters, checksum, index and timer to 0, and sets state to IDLE.
REQ-034 rst mid-frame discards the frame with no valid pulse and no counter change.

Structure
REQ-035 The shared package ubx_pkg holds the sync bytes, class/ID constants, POSLLH/VELNED lengths and field offsets, and the state enumeration.
REQ-036 The checksum is a sub-module ubx_fletcher8 (clear, byte enable, data in, ck_a/ck_b out).

Verification
REQ-037 Valid POSLLH with lon=0x12345678, lat=0x87654321, iTOW=1000, height=-5000 and correct checksum -> outputs take those values and pos_valid is high for exactly 1 cycle.
REQ-038 Valid VELNED with gSpeed=0x000001F4 -> ground_speed=500 and vel_valid pulses once; the POSLLH outputs are unchanged.
REQ-039 POSLLH with CK_A corrupted -> no pos_valid, outputs hold their old values, cks_err_cnt=1.
REQ-040 Bytes B5 B5 62 followed by a valid VELNED frame -> frame accepted (resync).
REQ-041 POSLLH header with length 20, followed by 20 payload bytes and a correct checksum -> drop_cnt=1 and no update; a following valid frame is accepted.
REQ-042 Stop mid-payload for TIMEOUT_CYCLES cycles -> in_frame low and drop_cnt+1; length 0x0200 with MAX_PAYLOAD=256 -> drop_cnt+1 at LEN_H.
